// File: rtl/monitor_sequencia.sv
// rtl/monitor_sequencia.sv - checker/event source for the 4-bit triangle sequence generator
// Optional saturating error counter enabled by MONITOR_SEQUENCIA_ERRCNT_EN.
module monitor_sequencia #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [W-1:0]     sequencia,
  output logic             locked,
  output logic             sentido,
  output logic             pico,
  output logic             vale,
  output logic [CNT_W-1:0] periodos,
  output logic             erro,
  output logic             erro_sticky,
  output logic [7:0]       erro_count
);

  typedef enum logic [2:0] {
    SYNC, BOTTOM, BOTTOM_HOLD, UP, TOP, TOP_HOLD, DOWN
  } state_t;

  localparam logic [W-1:0] MAX   = {W{1'b1}};
  localparam logic [W-1:0] MAXM1 = MAX - W'(1);
  localparam logic [W-1:0] ONE   = W'(1);

  state_t           state_q, state_d;
  logic [W-1:0]     prev_q, prev_d;
  logic             locked_q, locked_d;
  logic             sentido_q, sentido_d;
  logic             pico_q, pico_d;
  logic             vale_q, vale_d;
  logic             erro_q, erro_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] periodos_q, periodos_d;

  logic             ev_lock, ev_pico, ev_vale, ev_erro;
  logic [W:0]       exp_up, exp_dn, s_ext;

  // One extra bit keeps prev+1 / prev-1 from aliasing onto a legal sample.
  assign s_ext  = {1'b0, sequencia};
  assign exp_up = {1'b0, prev_q} + (W+1)'(1);
  assign exp_dn = {1'b0, prev_q} - (W+1)'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= SYNC;
      prev_q     <= '0;
      locked_q   <= 1'b0;
      sentido_q  <= 1'b0;
      pico_q     <= 1'b0;
      vale_q     <= 1'b0;
      erro_q     <= 1'b0;
      sticky_q   <= 1'b0;
      periodos_q <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      locked_q   <= locked_d;
      sentido_q  <= sentido_d;
      pico_q     <= pico_d;
      vale_q     <= vale_d;
      erro_q     <= erro_d;
      sticky_q   <= sticky_d;
      periodos_q <= periodos_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ev_lock = 1'b0;
    ev_pico = 1'b0;
    ev_vale = 1'b0;
    ev_erro = 1'b0;
    if (en) begin
      case (state_q)
        SYNC: begin
          if (sequencia == '0) begin
            state_d = BOTTOM;
            ev_lock = 1'b1;
          end
        end
        BOTTOM: begin
          if (sequencia == '0)      state_d = BOTTOM_HOLD;
          else if (sequencia == ONE) state_d = UP;
          else                       ev_erro = 1'b1;
        end
        BOTTOM_HOLD: begin
          if (sequencia == ONE) state_d = UP;
          else                  ev_erro = 1'b1;
        end
        UP: begin
          if (s_ext == exp_up) state_d = (sequencia == MAX) ? TOP : UP;
          else                 ev_erro = 1'b1;
        end
        TOP: begin
          if (sequencia == MAX) begin
            state_d = TOP_HOLD;
            ev_pico = 1'b1;
          end else begin
            ev_erro = 1'b1;
          end
        end
        TOP_HOLD: begin
          if (sequencia == MAXM1) state_d = DOWN;
          else                    ev_erro = 1'b1;
        end
        DOWN: begin
          if (s_ext == exp_dn) begin
            if (sequencia == '0) begin
              state_d = BOTTOM;
              ev_vale = 1'b1;
            end else begin
              state_d = DOWN;
            end
          end else begin
            ev_erro = 1'b1;
          end
        end
        default: state_d = SYNC;
      endcase
      // An offending zero is itself a valid bottom, so relock immediately.
      if (ev_erro) state_d = (sequencia == '0) ? BOTTOM : SYNC;
    end
  end

  always_comb begin
    prev_d     = en ? sequencia : prev_q;
    locked_d   = (state_d != SYNC);
    sentido_d  = sentido_q;
    if (ev_lock || ev_vale || (ev_erro && sequencia == '0)) sentido_d = 1'b0;
    if (ev_pico) sentido_d = 1'b1;
    pico_d     = ev_pico;
    vale_d     = ev_vale;
    erro_d     = ev_erro;
    sticky_d   = sticky_q | ev_erro;
    periodos_d = periodos_q + CNT_W'(ev_vale);
  end

`ifdef MONITOR_SEQUENCIA_ERRCNT_EN
  logic [7:0] errcnt_q, errcnt_d;

  always_comb begin
    errcnt_d = errcnt_q;
    if (ev_erro && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) errcnt_q <= '0;
    else      errcnt_q <= errcnt_d;
  end

  assign erro_count = errcnt_q;
`else
  assign erro_count = 8'd0;
`endif

  assign locked      = locked_q;
  assign sentido     = sentido_q;
  assign pico        = pico_q;
  assign vale        = vale_q;
  assign periodos    = periodos_q;
  assign erro        = erro_q;
  assign erro_sticky = sticky_q;

endmodule

// File: tb/tb_monitor_sequencia.sv
// tb/tb_monitor_sequencia.sv - scoreboard bench for monitor_sequencia
// Reference model tracks position within the canonical 32-sample period.
module tb_monitor_sequencia;

  logic       clk = 1'b0;
  logic       rst_n, en;
  logic [3:0] seq;
  logic       locked, sentido, pico, vale, erro, erro_sticky;
  logic [7:0] periodos, erro_count;

  always #5 clk = ~clk;

  monitor_sequencia #(.W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst_n), .en(en), .sequencia(seq),
    .locked(locked), .sentido(sentido), .pico(pico), .vale(vale),
    .periodos(periodos), .erro(erro), .erro_sticky(erro_sticky),
    .erro_count(erro_count)
  );

  logic [21:0] sb_q[$];
  int checks = 0, failures = 0;
  int n_pico = 0, n_vale = 0, n_erro = 0;

  // Model state: pos = index into the canonical period, -1 when unsynced.
  int   m_pos = -1;
  bit   m_sent = 0, m_sticky = 0;
  int   m_per = 0, m_cnt = 0;

  function automatic logic [3:0] pval(int k);
    if (k < 2)        return 4'd0;
    else if (k <= 16) return 4'(k - 1);
    else if (k == 17) return 4'd15;
    else              return 4'(32 - k);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(bit r, bit e, logic [3:0] s, string tag);
    bit p = 0, v = 0, er = 0;
    int np;
    logic [21:0] expv, obs;
    @(negedge clk);
    rst_n = r; en = e; seq = s;
    if (!r) begin
      m_pos = -1; m_sent = 0; m_sticky = 0; m_per = 0; m_cnt = 0;
    end else if (e) begin
      if (m_pos < 0) begin
        if (s == 0) begin m_pos = 0; m_sent = 0; end
      end else begin
        np = (m_pos + 1) % 32;
        if (s == pval(np) || (m_pos == 0 && s == 1)) begin
          if (s != pval(np)) np = 2;
          if (np == 17) begin p = 1; m_sent = 1; end
          if (np == 0)  begin v = 1; m_sent = 0; m_per = (m_per + 1) % 256; end
          m_pos = np;
        end else begin
          er = 1; m_sticky = 1;
`ifdef MONITOR_SEQUENCIA_ERRCNT_EN
          if (m_cnt < 255) m_cnt++;
`endif
          if (s == 0) begin m_pos = 0; m_sent = 0; end
          else m_pos = -1;
        end
      end
    end
    sb_q.push_back({m_pos >= 0, m_sent, p, v, 8'(m_per), er, m_sticky, 8'(m_cnt)});
    @(posedge clk);
    #1;
    obs = {locked, sentido, pico, vale, periodos, erro, erro_sticky, erro_count};
    if (pico) n_pico++;
    if (vale) n_vale++;
    if (erro) n_erro++;
    expv = sb_q.pop_front();
    check(tag, 32'(obs), 32'(expv));
  endtask

  task automatic run_period(string tag);
    for (int k = 0; k < 32; k++) step(1, 1, pval(k), tag);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; seq = 4'd0;
    step(0, 0, 4'd0, "reset0");
    step(0, 1, 4'd9, "reset1");

    // Steady trace: three periods plus the closing zero
    n_pico = 0; n_vale = 0; n_erro = 0;
    repeat (3) run_period("steady");
    step(1, 1, 4'd0, "steady_close");
    check("steady_pico_cnt", 32'(n_pico), 32'd3);
    check("steady_vale_cnt", 32'(n_vale), 32'd3);
    check("steady_no_erro", 32'(n_erro), 32'd0);
    check("steady_periodos", 32'(periodos), 32'd3);

    // Error injection in UP: 1,2,3,4,6 then relock on 0
    n_erro = 0;
    for (int k = 1; k <= 4; k++) step(1, 1, 4'(k), "up_ok");
    step(1, 1, 4'd6, "up_err");
    check("err_locked", 32'(locked), 32'd0);
    check("err_sticky", 32'(erro_sticky), 32'd1);
    step(1, 1, 4'd0, "relock");
    check("relock_locked", 32'(locked), 32'd1);
    check("relock_periodos", 32'(periodos), 32'd3);

    // Missing top hold
    n_pico = 0;
    for (int k = 2; k <= 16; k++) step(1, 1, pval(k), "to_top");
    step(1, 1, 4'd14, "no_hold");
    check("no_hold_pico", 32'(n_pico), 32'd0);
    step(1, 1, 4'd5, "sync_nonzero");
    step(1, 1, 4'd0, "relock2");

    // en gating mid-DOWN
    for (int k = 2; k <= 24; k++) step(1, 1, pval(k), "to_down");
    n_erro = 0;
    for (int i = 0; i < 5; i++) step(1, 0, 4'($urandom_range(15)), "gap");
    for (int k = 25; k < 32; k++) step(1, 1, pval(k), "resume");
    step(1, 1, 4'd0, "resume_vale");
    check("gap_no_erro", 32'(n_erro), 32'd0);

    // Reset mid-run at periodos=2 in UP
    step(0, 1, 4'd0, "rst_a");
    repeat (2) run_period("pre_rst");
    for (int k = 0; k <= 6; k++) step(1, 1, pval(k), "pre_rst_up");
    check("pre_rst_periodos", 32'(periodos), 32'd2);
    step(0, 1, 4'd6, "mid_rst");
    step(1, 1, 4'd3, "post_rst_sync");
    step(1, 1, 4'd0, "post_rst_lock");
    for (int k = 1; k < 32; k++) step(1, 1, pval(k), "post_rst");
    step(1, 1, 4'd0, "post_rst_vale");
    check("post_rst_periodos", 32'(periodos), 32'd1);

    // Counter wrap after 256 periods
    step(0, 1, 4'd0, "rst_b");
    repeat (256) run_period("wrap");
    step(1, 1, 4'd0, "wrap_close");
    check("wrap_periodos", 32'(periodos), 32'd0);

    // 300 errors: saturation (or constant 0 without the counter)
    for (int i = 0; i < 300; i++) begin
      step(1, 1, 4'd7, "sat_err");
      step(1, 1, 4'd0, "sat_lock");
    end
`ifdef MONITOR_SEQUENCIA_ERRCNT_EN
    check("erro_count_sat", 32'(erro_count), 32'd255);
`else
    check("erro_count_zero", 32'(erro_count), 32'd0);
`endif
    check("sat_periodos", 32'(periodos), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
